// File: rtl/sms_card_afr_cd_dfd.sv
// rtl/sms_card_afr_cd_dfd.sv - IBM 1620 SMS cards CD, DFD and AFR for console control
// CD and DFD are pure gates; AFR drives a lamp through a clocked persistence filter.
module sms_card_afr_cd_dfd #(
    parameter int LAMP_FILTER = 2,
    parameter int CNT_W       = 8
) (
    input  logic x,
    input  logic reset_n,
    input  logic cd_d,
    input  logic cd_p,
    input  logic cd_r,
    output logic cd_q,
    input  logic dfd_q,
    input  logic dfd_p,
    input  logic dfd_l,
    output logic dfd_c,
    input  logic afr_e,
    output logic afr_lamp,
    output logic afr_req
);

    localparam logic [CNT_W-1:0] LP_FILTER = CNT_W'(LAMP_FILTER);

    // Floating or unknown pins read as 0, matching the dot-OR pull-down on the cards.
    logic w_cd_d;
    logic w_cd_p;
    logic w_cd_r;
    logic w_dfd_q;
    logic w_dfd_p;
    logic w_dfd_l;
    logic w_afr_e;

    assign w_cd_d  = (cd_d  === 1'b1);
    assign w_cd_p  = (cd_p  === 1'b1);
    assign w_cd_r  = (cd_r  === 1'b1);
    assign w_dfd_q = (dfd_q === 1'b1);
    assign w_dfd_p = (dfd_p === 1'b1);
    assign w_dfd_l = (dfd_l === 1'b1);
    assign w_afr_e = (afr_e === 1'b1);

    assign cd_q    = ~(w_cd_d | w_cd_p | w_cd_r);
    assign dfd_c   = ~((w_dfd_q & w_dfd_p) | w_dfd_l);
    assign afr_req = ~w_afr_e;

    logic             r_lamp;
    logic [CNT_W-1:0] r_cnt;

    // The counter is cleared on every lamp update, so it can never exceed LAMP_FILTER.
    always_ff @(posedge x or negedge reset_n) begin
        if (!reset_n) begin
            r_lamp <= 1'b0;
            r_cnt  <= '0;
        end else if (afr_req == r_lamp) begin
            r_cnt  <= '0;
        end else if (r_cnt >= LP_FILTER) begin
            r_lamp <= afr_req;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign afr_lamp = r_lamp;

endmodule

// File: tb/tb_sms_card_afr_cd_dfd.sv
// tb/tb_sms_card_afr_cd_dfd.sv - self-checking bench for sms_card_afr_cd_dfd
module tb_sms_card_afr_cd_dfd;

    localparam int FILT = 2;

    logic x = 1'b0;
    logic reset_n;
    logic cd_d, cd_p, cd_r, dfd_q, dfd_p, dfd_l, afr_e;
    logic cd_q, dfd_c, afr_lamp, afr_req;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: lamp follows the request once it has differed for FILT+1 consecutive edges.
    bit m_lamp;
    int m_run;

    sms_card_afr_cd_dfd #(.LAMP_FILTER(FILT), .CNT_W(8)) dut (
        .x(x), .reset_n(reset_n),
        .cd_d(cd_d), .cd_p(cd_p), .cd_r(cd_r), .cd_q(cd_q),
        .dfd_q(dfd_q), .dfd_p(dfd_p), .dfd_l(dfd_l), .dfd_c(dfd_c),
        .afr_e(afr_e), .afr_lamp(afr_lamp), .afr_req(afr_req)
    );

    always #5 x = ~x;

    function automatic bit lvl(input logic v);
        return (v === 1'b1);
    endfunction

    function automatic bit exp_cd();
        return !(lvl(cd_d) || lvl(cd_p) || lvl(cd_r));
    endfunction

    function automatic bit exp_dfd();
        return !((lvl(dfd_q) && lvl(dfd_p)) || lvl(dfd_l));
    endfunction

    function automatic bit exp_req();
        return !lvl(afr_e);
    endfunction

    task automatic model_reset();
        m_lamp = 1'b0;
        m_run  = 0;
    endtask

    task automatic tick();
        @(posedge x);
        if (reset_n !== 1'b1) begin
            model_reset();
        end else if (exp_req() != m_lamp) begin
            m_run++;
            if (m_run == FILT + 1) begin
                m_lamp = exp_req();
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        #1;
    endtask

    function automatic logic pick4(input int sel);
        case (sel)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'bx;
            default: return 1'bz;
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        cd_d = 0; cd_p = 0; cd_r = 0;
        dfd_q = 0; dfd_p = 0; dfd_l = 0;
        afr_e = 1'b0;
        model_reset();
        tick(); tick();
        n_checks++;
        if (afr_lamp !== 1'b0) begin
            n_fail++; $display("FAIL reset_lamp: got %b want 0", afr_lamp);
        end
        n_checks++;
        if (afr_req !== 1'b1 || cd_q !== 1'b1 || dfd_c !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_live: req=%b cd_q=%b dfd_c=%b want 1 1 1", afr_req, cd_q, dfd_c);
        end
        afr_e = 1'b1;
        reset_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_cd();
        logic [3:0] seq;
        cd_p = 0; cd_r = 0;
        seq = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            cd_d = seq[i];
            #1;
            n_checks++;
            if (cd_q !== !seq[i]) begin
                n_fail++; $display("FAIL cd_toggle: d=%b got %b want %b", seq[i], cd_q, !seq[i]);
            end
        end
        cd_d = 1'bz;
        #1;
        n_checks++;
        if (cd_q !== 1'b1) begin
            n_fail++; $display("FAIL cd_z: got %b want 1", cd_q);
        end
        for (int i = 1; i < 8; i++) begin
            {cd_d, cd_p, cd_r} = 3'(i);
            #1;
            n_checks++;
            if (cd_q !== 1'b0) begin
                n_fail++; $display("FAIL cd_or: dpr=%0d got %b want 0", i, cd_q);
            end
        end
        cd_d = 0; cd_p = 0; cd_r = 0;
    endtask

    task automatic test_dfd();
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 4; i++) begin
                logic want;
                dfd_l = l[0];
                {dfd_q, dfd_p} = 2'(i);
                want = (l == 0 && i != 3) ? 1'b1 : 1'b0;
                #1;
                n_checks++;
                if (dfd_c !== want) begin
                    n_fail++; $display("FAIL dfd_gate: l=%0d qp=%0d got %b want %b", l, i, dfd_c, want);
                end
            end
        end
        dfd_l = 0;
    endtask

    task automatic test_afr_latency();
        afr_e = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++;
            if (afr_lamp !== (e >= 3)) begin
                n_fail++; $display("FAIL afr_on edge %0d: got %b want %b", e, afr_lamp, e >= 3);
            end
        end
        afr_e = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++;
            if (afr_lamp !== (e < 3)) begin
                n_fail++; $display("FAIL afr_off edge %0d: got %b want %b", e, afr_lamp, e < 3);
            end
        end
    endtask

    task automatic test_afr_glitch();
        afr_e = 1'b0;
        tick(); tick();
        afr_e = 1'b1;
        tick();
        n_checks++;
        if (afr_lamp !== 1'b0) begin
            n_fail++; $display("FAIL afr_glitch: got %b want 0", afr_lamp);
        end
        // Counter must have cleared: a fresh request needs the full three edges again.
        afr_e = 1'b0;
        tick(); tick();
        n_checks++;
        if (afr_lamp !== 1'b0) begin
            n_fail++; $display("FAIL afr_cnt_clear: got %b want 0 after 2 edges", afr_lamp);
        end
        tick();
        n_checks++;
        if (afr_lamp !== 1'b1) begin
            n_fail++; $display("FAIL afr_after_glitch: got %b want 1", afr_lamp);
        end
    endtask

    task automatic test_reset_midcount();
        // Lamp is lit with afr_e low from the previous task.
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (afr_lamp !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %b want 0", afr_lamp);
        end
        #1;
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_checks++;
            if (afr_lamp !== (e == 3)) begin
                n_fail++; $display("FAIL reset_restart edge %0d: got %b want %b", e, afr_lamp, e == 3);
            end
        end
        // Pending turn-off discarded by a reset pulse mid-count.
        afr_e = 1'b1;
        tick(); tick();
        #2; reset_n = 1'b0; model_reset(); #1; reset_n = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (afr_lamp !== 1'b0) begin
            n_fail++; $display("FAIL reset_discard: got %b want 0", afr_lamp);
        end
    endtask

    task automatic test_xz();
        cd_d = 1'bx; cd_p = 1'bz; cd_r = 1'bx;
        dfd_q = 1'bz; dfd_p = 1'bx; dfd_l = 1'bz;
        afr_e = 1'bz;
        #1;
        n_checks++;
        if (cd_q !== 1'b1 || dfd_c !== 1'b1 || afr_req !== 1'b1) begin
            n_fail++;
            $display("FAIL xz_outputs: cd_q=%b dfd_c=%b req=%b want 1 1 1", cd_q, dfd_c, afr_req);
        end
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_checks++;
            if (afr_lamp !== (e == 3) || $isunknown({cd_q, dfd_c, afr_req, afr_lamp})) begin
                n_fail++; $display("FAIL xz_lamp edge %0d: got %b want %b", e, afr_lamp, e == 3);
            end
        end
        afr_e = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cd_d = pick4($urandom_range(3)); cd_p = pick4($urandom_range(3));
            cd_r = pick4($urandom_range(3));
            dfd_q = pick4($urandom_range(3)); dfd_p = pick4($urandom_range(3));
            dfd_l = pick4($urandom_range(3));
            if ($urandom_range(3) == 0) afr_e = pick4($urandom_range(3));
            if ($urandom_range(60) == 0) begin
                reset_n = 1'b0; model_reset(); #1; reset_n = 1'b1;
            end
            #1;
            n_checks++;
            if (cd_q !== exp_cd() || dfd_c !== exp_dfd() || afr_req !== exp_req()) begin
                n_fail++;
                $display("FAIL rand_comb %0d: cd_q=%b/%b dfd_c=%b/%b req=%b/%b", c,
                         cd_q, exp_cd(), dfd_c, exp_dfd(), afr_req, exp_req());
            end
            tick();
            n_checks++;
            if (afr_lamp !== m_lamp) begin
                n_fail++; $display("FAIL rand_lamp %0d: got %b want %b", c, afr_lamp, m_lamp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cd();
        test_dfd();
        test_afr_latency();
        test_afr_glitch();
        test_reset_midcount();
        test_xz();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
